// File: rtl/dram_req_arb_if.sv
// dram_req_arb_if
// Bundles the two request ports (instruction fetch on port 0, load/store on
// port 1) and the SDRAM controller user-interface handshake seen by the
// arbiter.
//   s0_* / s1_* : req/we/addr/wdata/ctrl from each master, ack/rdata back.
//   m_*         : rd_en/wr_en/addr/wdata/ctrl toward the controller,
//                 rdata/busy coming back from it.
// Modports:
//   slave  - the arbiter's view (serves the request masters, drives the
//            controller enables).
//   master - the environment's view (request masters plus the controller).
interface dram_req_arb_if;
  logic        s0_req;
  logic        s0_we;
  logic [31:0] s0_addr;
  logic [31:0] s0_wdata;
  logic [2:0]  s0_ctrl;
  logic        s0_ack;
  logic [31:0] s0_rdata;

  logic        s1_req;
  logic        s1_we;
  logic [31:0] s1_addr;
  logic [31:0] s1_wdata;
  logic [2:0]  s1_ctrl;
  logic        s1_ack;
  logic [31:0] s1_rdata;

  logic        m_rd_en;
  logic        m_wr_en;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_ctrl;
  logic [31:0] m_rdata;
  logic        m_busy;

  modport slave (
    input  s0_req, s0_we, s0_addr, s0_wdata, s0_ctrl,
    input  s1_req, s1_we, s1_addr, s1_wdata, s1_ctrl,
    output s0_ack, s0_rdata, s1_ack, s1_rdata,
    output m_rd_en, m_wr_en, m_addr, m_wdata, m_ctrl,
    input  m_rdata, m_busy
  );

  modport master (
    output s0_req, s0_we, s0_addr, s0_wdata, s0_ctrl,
    output s1_req, s1_we, s1_addr, s1_wdata, s1_ctrl,
    input  s0_ack, s0_rdata, s1_ack, s1_rdata,
    input  m_rd_en, m_wr_en, m_addr, m_wdata, m_ctrl,
    output m_rdata, m_busy
  );
endinterface

// File: rtl/dram_req_arb.sv
// dram_req_arb
// Two-port round-robin request arbiter in front of the SDRAM user-interface
// controller. One request is granted at a time; the winner's fields are
// latched, the level-sensitive rd/wr enable is held until the controller
// raises busy (or an accept timeout expires), the read result is captured
// when busy falls, and a one-cycle ack carries it back to the winner.
// Ports:
//   clk   - system clock (same clock as the controller)
//   rst   - synchronous active-high reset
//   bus   - request ports and controller handshake (slave modport)
//   o_err - sticky flag: controller never accepted a request in time
module dram_req_arb #(
  parameter int unsigned ACCEPT_TIMEOUT = 32'd255
) (
  input  logic           clk,
  input  logic           rst,
  dram_req_arb_if.slave  bus,
  output logic           o_err
);

  localparam int unsigned     CNT_W     = $clog2(ACCEPT_TIMEOUT + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACCEPT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r, next_state_s;
  logic        grant_r, grant_s;
  logic        last_grant_r, last_grant_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0] rdata_q_r, rdata_q_s;
  logic        err_r, err_s;
  logic        rd_en_r, rd_en_s;
  logic        wr_en_r, wr_en_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [2:0]  ctrl_r, ctrl_s;
  logic        ack0_r, ack0_s;
  logic        ack1_r, ack1_s;
  logic [31:0] rdata0_r, rdata0_s;
  logic [31:0] rdata1_r, rdata1_s;

  logic        win_s;
  logic        win_we_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;
  logic [2:0]  win_ctrl_s;

  // Round-robin winner selection and mux of the winner's request fields.
  always_comb begin
    win_s       = 1'b0;
    win_we_s    = bus.s0_we;
    win_addr_s  = bus.s0_addr;
    win_wdata_s = bus.s0_wdata;
    win_ctrl_s  = bus.s0_ctrl;
    // On contention the port that was not served last wins; otherwise the
    // only requester wins (s1_req alone selects port 1).
    if (bus.s0_req && bus.s1_req) begin
      win_s = ~last_grant_r;
    end else begin
      win_s = bus.s1_req;
    end
    if (win_s) begin
      win_we_s    = bus.s1_we;
      win_addr_s  = bus.s1_addr;
      win_wdata_s = bus.s1_wdata;
      win_ctrl_s  = bus.s1_ctrl;
    end else begin
      win_we_s    = bus.s0_we;
      win_addr_s  = bus.s0_addr;
      win_wdata_s = bus.s0_wdata;
      win_ctrl_s  = bus.s0_ctrl;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    next_state_s = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    rdata_q_s    = rdata_q_r;
    err_s        = err_r;
    rd_en_s      = rd_en_r;
    wr_en_s      = wr_en_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    ctrl_s       = ctrl_r;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    rdata0_s     = 32'h0000_0000;
    rdata1_s     = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        // A busy controller here means refresh or an operation accepted
        // before a reset; never issue on top of it.
        if (!bus.m_busy && (bus.s0_req || bus.s1_req)) begin
          grant_s      = win_s;
          addr_s       = win_addr_s;
          wdata_s      = win_wdata_s;
          ctrl_s       = win_ctrl_s;
          rd_en_s      = ~win_we_s;
          wr_en_s      = win_we_s;
          cnt_s        = CNT_ZERO;
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.m_busy) begin
          rd_en_s      = 1'b0;
          wr_en_s      = 1'b0;
          next_state_s = ST_DONE;
        end else if (cnt_r == CNT_LIMIT) begin
          // Controller never accepted: abandon and answer with zero data.
          rd_en_s      = 1'b0;
          wr_en_s      = 1'b0;
          err_s        = 1'b1;
          rdata_q_s    = 32'h0000_0000;
          next_state_s = ST_RESP;
        end else begin
          cnt_s        = cnt_r + CNT_ONE;
          next_state_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        if (!bus.m_busy) begin
          rdata_q_s    = bus.m_rdata;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_RESP: begin
        if (grant_r) begin
          ack1_s   = 1'b1;
          rdata1_s = rdata_q_r;
        end else begin
          ack0_s   = 1'b1;
          rdata0_s = rdata_q_r;
        end
        last_grant_s = grant_r;
        next_state_s = ST_IDLE;
      end
      default: begin
        rd_en_s      = 1'b0;
        wr_en_s      = 1'b0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= CNT_ZERO;
      rdata_q_r    <= 32'h0000_0000;
      err_r        <= 1'b0;
      rd_en_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      ctrl_r       <= 3'b000;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      rdata0_r     <= 32'h0000_0000;
      rdata1_r     <= 32'h0000_0000;
    end else begin
      state_r      <= next_state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      rdata_q_r    <= rdata_q_s;
      err_r        <= err_s;
      rd_en_r      <= rd_en_s;
      wr_en_r      <= wr_en_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      ctrl_r       <= ctrl_s;
      ack0_r       <= ack0_s;
      ack1_r       <= ack1_s;
      rdata0_r     <= rdata0_s;
      rdata1_r     <= rdata1_s;
    end
  end

  assign bus.m_rd_en  = rd_en_r;
  assign bus.m_wr_en  = wr_en_r;
  assign bus.m_addr   = addr_r;
  assign bus.m_wdata  = wdata_r;
  assign bus.m_ctrl   = ctrl_r;
  assign bus.s0_ack   = ack0_r;
  assign bus.s0_rdata = rdata0_r;
  assign bus.s1_ack   = ack1_r;
  assign bus.s1_rdata = rdata1_r;
  assign o_err        = err_r;

endmodule

// File: tb/tb_dram_req_arb.sv
// Testbench for dram_req_arb: a table of per-cycle vectors covers a single
// load followed back-to-back by a store; hand-written sequences cover
// contention, a busy controller at request time, accept timeout and reset
// while the controller is busy.
module tb_dram_req_arb;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic o_err;

  dram_req_arb_if bus();

  dram_req_arb #(.ACCEPT_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .o_err (o_err)
  );

  always #5 clk = ~clk;

  // Controller model: samples an enable when idle, then stays busy for
  // mdl_len cycles starting the cycle after. mdl_force emulates refresh.
  int          mdl_left  = 0;
  int          mdl_len   = 6;
  bit          mdl_on    = 1'b1;
  bit          mdl_force = 1'b0;
  logic [31:0] mdl_rdata = 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mdl_left != 0) mdl_left <= mdl_left - 1;
    else if (mdl_on && (bus.m_rd_en || bus.m_wr_en)) mdl_left <= mdl_len;
  end
  assign bus.m_busy  = (mdl_left != 0) || mdl_force;
  assign bus.m_rdata = mdl_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rd_en"}, bus.m_rd_en, 1'b0);
    chk1({tag, "_wr_en"}, bus.m_wr_en, 1'b0);
    chk({tag, "_addr"}, bus.m_addr, 32'h0);
    chk({tag, "_wdata"}, bus.m_wdata, 32'h0);
    chk({tag, "_ctrl"}, {29'h0, bus.m_ctrl}, 32'h0);
    chk1({tag, "_ack0"}, bus.s0_ack, 1'b0);
    chk1({tag, "_ack1"}, bus.s1_ack, 1'b0);
    chk({tag, "_rdata0"}, bus.s0_rdata, 32'h0);
    chk({tag, "_rdata1"}, bus.s1_rdata, 32'h0);
    chk1({tag, "_err"}, o_err, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One row = inputs applied before an edge + outputs expected after it.
  typedef struct {
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic [2:0]  ctl0, ctl1;
    logic        e_rd, e_wr, e_ack0, e_ack1, chk_rdat;
    logic [31:0] e_addr, e_wd, e_rdat;
    logic [2:0]  e_ctl;
  } vec_t;

  vec_t vecs[$];

  // Scenario: which port carries the transaction and its fields.
  bit          sc_port;
  logic        sc_we;
  logic [31:0] sc_addr, sc_wd;
  logic [2:0]  sc_ctl;

  // live=0 drives inverted (junk) fields on the scenario port, checking
  // that fields are latched at grant; the other port always sees junk.
  task automatic add_row(input bit r0, input bit r1, input bit live, input bit erd,
                         input bit ewr, input bit ea0, input bit ea1, input bit ck,
                         input logic [31:0] erdat);
    vec_t v;
    bit sel0, sel1;
    sel0 = live && (sc_port == 1'b0);
    sel1 = live && (sc_port == 1'b1);
    v.req0 = r0;  v.req1 = r1;
    v.we0   = sel0 ? sc_we   : ~sc_we;    v.we1   = sel1 ? sc_we   : ~sc_we;
    v.addr0 = sel0 ? sc_addr : ~sc_addr;  v.addr1 = sel1 ? sc_addr : ~sc_addr;
    v.wd0   = sel0 ? sc_wd   : ~sc_wd;    v.wd1   = sel1 ? sc_wd   : ~sc_wd;
    v.ctl0  = sel0 ? sc_ctl  : ~sc_ctl;   v.ctl1  = sel1 ? sc_ctl  : ~sc_ctl;
    v.e_rd = erd;  v.e_wr = ewr;  v.e_ack0 = ea0;  v.e_ack1 = ea1;
    v.chk_rdat = ck;  v.e_rdat = erdat;
    v.e_addr = sc_addr;  v.e_wd = sc_wd;  v.e_ctl = sc_ctl;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_t, en_cnt, n_acks, cnt0, cnt1;
    bit seen_en, got;
    logic busy_before;

    // ---------- vector table ----------
    // Load on port 1: grant E0, enable E0..E1, busy seen E2..E7,
    // capture E8, ack E9.
    sc_port = 1'b1; sc_we = 1'b0; sc_addr = 32'h8000_0002; sc_wd = 32'hA5A5_0001; sc_ctl = 3'd2;
    //       r0 r1 lv rd wr a0 a1 ck rdata
    add_row(0, 1, 1, 1, 0, 0, 0, 0, 32'h0);
    add_row(0, 1, 0, 1, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) add_row(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    add_row(0, 1, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    // Store on port 0 back-to-back: grant one cycle after the load's ack.
    sc_port = 1'b0; sc_we = 1'b1; sc_addr = 32'h0000_0100; sc_wd = 32'h1234_5678; sc_ctl = 3'd0;
    add_row(1, 0, 1, 0, 1, 0, 0, 0, 32'h0);
    add_row(1, 0, 0, 0, 1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 7; i++) add_row(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    add_row(1, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    add_row(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // ---------- reset ----------
    rst = 1'b1;
    bus.s0_req = 1'b0; bus.s0_we = 1'b0; bus.s0_addr = 32'h0; bus.s0_wdata = 32'h0; bus.s0_ctrl = 3'd0;
    bus.s1_req = 1'b0; bus.s1_we = 1'b0; bus.s1_addr = 32'h0; bus.s1_wdata = 32'h0; bus.s1_ctrl = 3'd0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // ---------- apply table ----------
    for (int k = 0; k < vecs.size(); k++) begin
      bus.s0_req = vecs[k].req0; bus.s0_we = vecs[k].we0; bus.s0_addr = vecs[k].addr0;
      bus.s0_wdata = vecs[k].wd0; bus.s0_ctrl = vecs[k].ctl0;
      bus.s1_req = vecs[k].req1; bus.s1_we = vecs[k].we1; bus.s1_addr = vecs[k].addr1;
      bus.s1_wdata = vecs[k].wd1; bus.s1_ctrl = vecs[k].ctl1;
      tick();
      chk1($sformatf("vec%0d_rd_en", k), bus.m_rd_en, vecs[k].e_rd);
      chk1($sformatf("vec%0d_wr_en", k), bus.m_wr_en, vecs[k].e_wr);
      chk($sformatf("vec%0d_addr", k), bus.m_addr, vecs[k].e_addr);
      chk($sformatf("vec%0d_wdata", k), bus.m_wdata, vecs[k].e_wd);
      chk($sformatf("vec%0d_ctrl", k), {29'h0, bus.m_ctrl}, {29'h0, vecs[k].e_ctl});
      chk1($sformatf("vec%0d_ack0", k), bus.s0_ack, vecs[k].e_ack0);
      chk1($sformatf("vec%0d_ack1", k), bus.s1_ack, vecs[k].e_ack1);
      chk1($sformatf("vec%0d_err", k), o_err, 1'b0);
      if (vecs[k].chk_rdat) begin
        chk($sformatf("vec%0d_rdata1", k), bus.s1_rdata, vecs[k].e_rdat);
      end
    end

    // ---------- contention: both rise together after reset ----------
    do_reset();
    mdl_rdata = 32'hCAFE_F00D;
    bus.s0_we = 1'b0; bus.s0_addr = 32'h0000_0010; bus.s0_ctrl = 3'd2;
    bus.s1_we = 1'b0; bus.s1_addr = 32'h0000_0020; bus.s1_ctrl = 3'd2;
    bus.s0_req = 1'b1; bus.s1_req = 1'b1;
    n_acks = 0; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 300 && n_acks < 8; c++) begin
      tick();
      if (bus.s0_ack && bus.s1_ack) chk1("cont_double_ack", 1'b1, 1'b0);
      if (bus.s0_ack || bus.s1_ack) begin
        chk1($sformatf("cont_order%0d", n_acks), bus.s1_ack, n_acks[0]);
        if (bus.s1_ack) begin
          chk("cont_rdata1", bus.s1_rdata, 32'hCAFE_F00D);
          cnt1++;
          if (cnt1 == 4) bus.s1_req = 1'b0;
        end else begin
          chk("cont_rdata0", bus.s0_rdata, 32'hCAFE_F00D);
          cnt0++;
          if (cnt0 == 4) bus.s0_req = 1'b0;
        end
        n_acks++;
      end
    end
    chk("cont_total_acks", 32'(n_acks), 32'd8);
    bus.s0_req = 1'b0; bus.s1_req = 1'b0;
    tick();

    // ---------- controller busy (refresh) at request time ----------
    mdl_force = 1'b1;
    mdl_rdata = 32'h0BAD_F00D;
    bus.s0_we = 1'b0; bus.s0_addr = 32'h0000_0044; bus.s0_ctrl = 3'd1;
    bus.s0_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk1($sformatf("refresh_no_en%0d", c), bus.m_rd_en | bus.m_wr_en, 1'b0);
    end
    mdl_force = 1'b0;
    tick();
    chk1("refresh_grant", bus.m_rd_en, 1'b1);
    chk("refresh_addr", bus.m_addr, 32'h0000_0044);
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (bus.s0_ack) begin
        got = 1'b1;
        chk("refresh_rdata", bus.s0_rdata, 32'h0BAD_F00D);
        bus.s0_req = 1'b0;
      end
    end
    chk1("refresh_ack_seen", got, 1'b1);
    tick();

    // ---------- accept timeout ----------
    mdl_on = 1'b0;
    bus.s0_we = 1'b0; bus.s0_addr = 32'h0000_0088; bus.s0_ctrl = 3'd2;
    bus.s0_req = 1'b1;
    tick();
    chk1("to_grant", bus.m_rd_en, 1'b1);
    chk1("to_err_before", o_err, 1'b0);
    en_cnt = 1; ack_t = 0;
    for (int t = 1; t <= int'(TO) + 6 && ack_t == 0; t++) begin
      tick();
      if (bus.m_rd_en) en_cnt++;
      if (bus.s0_ack) begin
        ack_t = t;
        chk("to_rdata", bus.s0_rdata, 32'h0);
        chk1("to_err_at_ack", o_err, 1'b1);
        bus.s0_req = 1'b0;
      end
    end
    chk("to_ack_time", 32'(ack_t), 32'(TO + 2));
    chk("to_enable_cycles", 32'(en_cnt), 32'(TO + 1));
    for (int c = 0; c < 5; c++) tick();
    chk1("to_err_sticky", o_err, 1'b1);
    do_reset();
    chk1("to_err_cleared", o_err, 1'b0);
    mdl_on = 1'b1;

    // ---------- reset while controller is busy (DONE) ----------
    mdl_len = 10;
    mdl_rdata = 32'h7777_1234;
    bus.s0_we = 1'b0; bus.s0_addr = 32'h0000_0080; bus.s0_ctrl = 3'd2;
    bus.s0_req = 1'b1;
    tick();
    chk1("rd_grant", bus.m_rd_en, 1'b1);
    tick();
    tick();
    chk1("rd_in_done", bus.m_rd_en, 1'b0);
    tick();
    tick();
    do_reset();
    chk_all_zero("rst_mid_done");
    seen_en = 1'b0; got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      busy_before = bus.m_busy;
      tick();
      if (!seen_en && (bus.m_rd_en || bus.m_wr_en)) begin
        seen_en = 1'b1;
        chk1("rst_grant_while_busy", busy_before, 1'b0);
      end
      if (bus.s0_ack) begin
        got = 1'b1;
        chk("rst_new_rdata", bus.s0_rdata, 32'h7777_1234);
        bus.s0_req = 1'b0;
      end
    end
    chk1("rst_new_ack_seen", got, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_req_arb.md
# dram_req_arb

Two-port request arbiter placed directly upstream of the SDRAM user-interface controller (`DRAM_conRV`). It accepts independent instruction-fetch (port 0) and data/load-store (port 1) requests. Each request is held by the master until it is acknowledged. The arbiter grants one request at a time using round-robin priority and drives the controller's level-sensitive `i_rd_en`/`i_wr_en`/`o_busy` handshake. It then returns read data with a one-cycle acknowledge pulse and flags a controller that never accepts a request.

## Interface
- `ACCEPT_TIMEOUT`, 255: cycles the enable may be held without `m_busy` rising before the request is abandoned.
- `clk`  in  1  system clock (the controller's `clk`).
- `rst`  in  1  synchronous reset, active-high.
- `s0_req`, `s1_req`  in  1  request; held high until the matching ack.
- `s0_we`, `s1_we`  in  1  1 = store, 0 = load.
- `s0_addr`, `s1_addr`  in  32  byte address; may be unaligned.
- `s0_wdata`, `s1_wdata`  in  32  store data.
- `s0_ctrl`, `s1_ctrl`  in  3  access size and sign, in controller `i_ctrl` encoding.
- `s0_ack`, `s1_ack`  out  1  one-cycle completion pulse.
- `s0_rdata`, `s1_rdata`  out  32  load result; valid only while the matching ack is high.
- `m_rd_en`, `m_wr_en`  out  1  connect to controller `i_rd_en` / `i_wr_en`.
- `m_addr`, `m_wdata`  out  32  connect to controller `i_addr` / `i_data`.
- `m_ctrl`  out  3  connect to controller `i_ctrl`.
- `m_rdata`  in  32  controller `o_data`.
- `m_busy`  in  1  controller `o_busy`.
- `o_err`  out  1  sticky accept-timeout flag.

All outputs are registered. Reset values are 0 for every output, with `state`=IDLE and `last_grant`=1.

## Operation
- **IDLE**
  - If `m_busy`=0 and any `sN_req`=1, select the grant winner.
  - When only one port requests, that port wins.
  - When both request, the port ≠ `last_grant` wins.
  - Register the winner's `we`, `addr`, `wdata` and `ctrl` into the `m_*` outputs.
  - Set `m_rd_en`=~we or `m_wr_en`=we, record `grant`, clear the timeout counter, then go to ISSUE.
  - If `m_busy`=1 (refresh or an operation started before reset), stay in IDLE.
- **ISSUE**
  - Hold the enable and the `m_*` fields.
  - If `m_busy`=1, drop both enables next cycle and go to DONE.
  - Otherwise increment the counter. When the counter reaches `ACCEPT_TIMEOUT`, drop the enables, set `o_err`=1 and go to RESP with captured data = 0.
- **DONE**
  - Wait for `m_busy`=0. On that edge, capture `m_rdata` into `rdata_q` (stores capture too, but the value is ignored), then go to RESP.
- **RESP**
  - Pulse `s[grant]_ack` for one cycle, with `s[grant]_rdata`=`rdata_q`.
  - Set `last_grant`=`grant` and go to IDLE.
- `m_addr`, `m_wdata` and `m_ctrl` keep their last values outside ISSUE; only the enables qualify them.
- Request fields are latched at grant. Master changes after grant have no effect on the transaction in flight.
- A master's `req` seen in the cycle after its ack is treated as a new request.
- Unaligned and split accesses are handled entirely by the controller; the arbiter passes `addr` and `ctrl` through unmodified.
- **Reset mid-operation:** return to IDLE, enables low, no ack. The controller finishes any accepted operation on its own, and the IDLE `m_busy` check prevents issue until it is done.
- `o_err` clears only on `rst`.

## Timing
- Request sampled in IDLE at edge T0 → enable high from T1.
- The controller asserts `m_busy` the cycle after it samples the enable. The arbiter sees `m_busy` at T2, so the enable is high for 2 cycles.
- Last `m_busy`=1 cycle is Tb → `rdata_q` loaded at edge Tb+1 → ack high during Tb+2.
- Arbiter overhead is 3 cycles beyond the controller busy window.
- Back-to-back throughput: one request per (busy window + 4) cycles. The next grant can enable one cycle after RESP.
- Counter width is clog2(`ACCEPT_TIMEOUT`+1). A timeout ack occurs `ACCEPT_TIMEOUT`+2 cycles after the grant.
- **Simultaneous events:**
  - Both `req` rise on the same edge after reset → port 0 is served first, then port 1.
  - Under continuous dual requests, grants strictly alternate.

## Test plan
- **Single load:** `s1_req`, `we`=0, `addr`=0x8000_0002, `ctrl`=2. A controller model holds busy for 6 cycles and returns 0xDEADBEEF. Require:
  - `m_rd_en` high for exactly 2 cycles with `m_addr`=0x8000_0002 and `m_ctrl`=2;
  - `s1_ack` for 1 cycle with `s1_rdata`=0xDEADBEEF, 3 cycles after busy falls;
  - `s0_ack` stays 0.
- **Store:** `s0_req`, `we`=1, `wdata`=0x1234_5678, `ctrl`=0 → `m_wr_en` pulse with `m_wdata`=0x1234_5678 and `m_ctrl`=0; `m_rd_en` never asserts; one `s0_ack`.
- **Contention:** both ports hold `req` for 4 transactions each → ack order 0,1,0,1,0,1,0,1; never two acks in the same cycle.
- **Busy at request:** `m_busy` held high for 20 cycles (refresh) while `s0_req`=1 → no enable until `m_busy`=0; then the normal transaction completes.
- **Timeout:** the model never raises busy; `ACCEPT_TIMEOUT`=8 → enable drops, `o_err`=1, `s0_ack` with `s0_rdata`=0 at grant+10; `o_err` stays 1 until `rst`.
- **Reset mid-DONE:** `rst` for 1 cycle while busy → all outputs 0 next cycle; a new request issues only after the model's busy falls and completes correctly.
